// File: rtl/ucode_pkg.sv
// ============================================================================
// ucode_pkg
// Shared widths, control-store addresses, opcode set and dispatch map
// for the microprogram sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ucode_pkg;

    localparam int UPC_W = 5;

    localparam logic [UPC_W-1:0] FETCH1   = 5'd0;
    localparam logic [UPC_W-1:0] FETCH2   = 5'd1;
    localparam logic [UPC_W-1:0] JMPNZN1  = 5'd13;
    localparam logic [UPC_W-1:0] UPC_LAST = 5'd26;

    typedef enum logic [4:0] {
        OP_RSTALL = 5'd0,
        OP_CONST  = 5'd1,
        OP_MOV    = 5'd2,
        OP_SIZE   = 5'd3,
        OP_JMPNZ  = 5'd4,
        OP_MOVMSB = 5'd5,
        OP_MOVLSB = 5'd6,
        OP_ADDX   = 5'd7,
        OP_ADDY   = 5'd8,
        OP_ADD    = 5'd9,
        OP_SUB    = 5'd10,
        OP_MUL    = 5'd11,
        OP_LOAD   = 5'd12,
        OP_STORE  = 5'd13,
        OP_INCI   = 5'd14,
        OP_RSTI   = 5'd15
    } opcode_t;

    // Entry address for an opcode; illegal codes map to FETCH1 (refetch).
    function automatic logic [UPC_W-1:0] entry_addr(input logic [4:0] op, input logic z);
        logic [UPC_W-1:0] addr;
        addr = FETCH1;
        case (op)
            OP_RSTALL: addr = 5'd2;
            OP_CONST:  addr = 5'd3;
            OP_MOV:    addr = 5'd4;
            OP_SIZE:   addr = 5'd5;
            OP_JMPNZ:  addr = z ? JMPNZN1 : 5'd10;
            OP_MOVMSB: addr = 5'd14;
            OP_MOVLSB: addr = 5'd15;
            OP_ADDX:   addr = 5'd16;
            OP_ADDY:   addr = 5'd17;
            OP_ADD:    addr = 5'd18;
            OP_SUB:    addr = 5'd19;
            OP_MUL:    addr = 5'd20;
            OP_LOAD:   addr = 5'd21;
            OP_STORE:  addr = 5'd23;
            OP_INCI:   addr = 5'd25;
            OP_RSTI:   addr = 5'd26;
            default:   addr = FETCH1;
        endcase
        return addr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ucode_dispatch.sv
// ============================================================================
// ucode_dispatch
// Combinational opcode + Z flag to routine entry address, with legality flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ucode_dispatch
    import ucode_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       z_flag,
    output logic [4:0] entry,
    output logic       legal
);

    // Only the lower sixteen codes are populated.
    assign legal = ~opcode[4];
    assign entry = entry_addr(opcode, z_flag);

endmodule

`default_nettype wire

// File: rtl/micro_sequencer.sv
// ============================================================================
// micro_sequencer
// Control-store address sequencer: uPC register, opcode dispatch, error
// capture and dispatched-instruction counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module micro_sequencer
    import ucode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  cs_next,
    input  logic [4:0]  opcode,
    input  logic        z_flag,
    input  logic        stall,
    output logic [4:0]  upc,
    output logic        instr_start,
    output logic        err_illegal,
    output logic [4:0]  err_code,
    output logic [15:0] instr_count
);

    logic [UPC_W-1:0] upc_q;
    logic [UPC_W-1:0] upc_d;
    logic [15:0]      instr_cnt_q;
    logic             err_q;
    logic [4:0]       err_code_q;

    logic [UPC_W-1:0] disp_entry;
    logic             disp_legal;
    logic             dispatch_ok;
    logic             err_hit;
    logic [4:0]       err_val;

    ucode_dispatch u_dispatch (
        .opcode (opcode),
        .z_flag (z_flag),
        .entry  (disp_entry),
        .legal  (disp_legal)
    );

    // Next-address selection; cs_next is undefined at FETCH2 and unpopulated
    // addresses, so it is never used there.
    always_comb begin
        upc_d       = upc_q;
        dispatch_ok = 1'b0;
        err_hit     = 1'b0;
        err_val     = upc_q;
        if (!stall) begin
            if (upc_q == FETCH2) begin
                if (disp_legal) begin
                    upc_d       = disp_entry;
                    dispatch_ok = 1'b1;
                end else begin
                    upc_d   = FETCH1;
                    err_hit = 1'b1;
                    err_val = opcode;
                end
            end else if (upc_q > UPC_LAST) begin
                upc_d   = FETCH1;
                err_hit = 1'b1;
                err_val = upc_q;
            end else begin
                upc_d = cs_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc_q <= FETCH1;
        end else begin
            upc_q <= upc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q <= 16'd0;
        end else if (dispatch_ok) begin
            instr_cnt_q <= instr_cnt_q + 16'd1;
        end
    end

    // First error wins; later errors leave the captured code untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_code_q <= 5'd0;
        end else if (err_hit && !err_q) begin
            err_q      <= 1'b1;
            err_code_q <= err_val;
        end
    end

    assign upc         = upc_q;
    assign instr_start = (upc_q == FETCH1) && !stall;
    assign err_illegal = err_q;
    assign err_code    = err_code_q;
    assign instr_count = instr_cnt_q;

endmodule

`default_nettype wire

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer driving the control-store address of the core's control unit. Holds the 5-bit micro-program counter (uPC) presented to the 37-bit microcode ROM, consumes the ROM's next-address field, and performs opcode dispatch at FETCH2 and the Z-flag branch for JMPNZ. Sits between the instruction fetch path (opcode, Z flag, memory stall) and the control-store ROM.

## Interface
- No parameters; all widths and addresses are fixed constants in `ucode_pkg`.
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cs_next`  in  5  next-address field of current control word (ROM cs[4:0])
- `opcode`  in  5  opcode of instruction being fetched; valid during FETCH2
- `z_flag`  in  1  ALU zero flag, valid during FETCH2
- `stall`  in  1  memory/bus wait; freezes sequencing
- `upc`  out  5  control-store address to ROM
- `instr_start`  out  1  high while uPC = FETCH1 and not stalled
- `err_illegal`  out  1  sticky illegal-opcode / illegal-address flag
- `err_code`  out  5  offending opcode or address captured at first error
- `instr_count`  out  16  count of successfully dispatched instructions

## Operation
- Reset values: `upc`=0 (FETCH1), `err_illegal`=0, `err_code`=0, `instr_count`=0; `instr_start`=1 after reset since uPC=FETCH1.
- Next-uPC selection, evaluated each cycle, priority high to low:
  - `stall`=1: uPC holds; no dispatch, count, or error update.
  - uPC = FETCH2 (1): dispatch; `cs_next` is ignored (ROM drives X there).
  - uPC ≥ 27 (unpopulated ROM): next uPC = 0, error raised with `err_code`=uPC.
  - otherwise: next uPC = `cs_next`.
- Dispatch map (opcode → entry): RSTALL 0→2, CONST 1→3, MOV 2→4, SIZE 3→5, JMPNZ 4→10 if `z_flag`=0 else 13, MOVMSB 5→14, MOVLSB 6→15, ADDX 7→16, ADDY 8→17, ADD 9→18, SUB 10→19, MUL 11→20, LOAD 12→21, STORE 13→23, INCI 14→25, RSTI 15→26.
- Opcodes 16–31 are illegal: next uPC = 0 (refetch), error raised, `err_code`=opcode, `instr_count` not incremented.
- Legal dispatch increments `instr_count`; wraps 0xFFFF→0x0000 silently.
- Error capture: `err_illegal` set on first error; `err_code` holds first value only; both cleared only by `rst`.
- Routine termination: microinstructions whose `cs_next`=0 return to FETCH1; no special handling required.

## Timing
- `upc` is a register; ROM is combinational, so the control word for `upc` is valid in the same cycle. Each microinstruction occupies exactly one cycle unless `stall`.
- `opcode`/`z_flag` sampled at the rising edge ending FETCH2; entry address appears on `upc` in the next cycle (dispatch latency 1).
- `stall` sampled each edge; a stall during FETCH2 defers dispatch; `opcode`/`z_flag` are resampled on the first unstalled edge.
- `instr_start` is combinational from `upc` and `stall`.
- `rst` asserted mid-routine: `upc` goes to 0 immediately (asynchronous), all counters/flags cleared; first FETCH1 cycle after release.
- Illegal opcode and counter wrap on the same edge cannot coincide (illegal does not count).

## Structure
- `ucode_pkg`: uPC width (5), address constants FETCH1=0, FETCH2=1, JMPNZN1=13, UPC_LAST=26, opcode enum (16 legal codes), and the `entry_addr(opcode, z)` dispatch function.
- One sub-module natural: `ucode_dispatch` (combinational opcode+Z → entry address, legal flag); sequencer register, counter, and error capture in `micro_sequencer`.

## Test plan
- Reset then run with `cs_next` tied to ROM model, opcode=9 (ADD) at FETCH2 → `upc` sequence 0,1,18,0; `instr_count`=1.
- opcode=4, `z_flag`=0 → `upc` 1→10→11→12→0; repeat with `z_flag`=1 → 1→13→0.
- `stall`=1 for 3 cycles during FETCH2 with opcode=12 → `upc` stays 1 for 4 cycles, then 21, 22, 0; count increments once.
- opcode=20 at FETCH2 → `upc` 0 next cycle, `err_illegal`=1, `err_code`=20, count unchanged; later opcode=31 leaves `err_code`=20.
- Force `cs_next`=29 from a routine → next `upc`=29 then 0; `err_illegal`=1, `err_code`=29.
- Assert `rst` mid-SIZE routine (`upc`=7) → `upc`=0 asynchronously before next edge; preload `instr_count`=0xFFFF via dispatches, one more legal dispatch → 0x0000.
